pingpong_sram_ctrl: RTL and testbench

- Controller for the two-bank ping-pong activation buffer (two dual-port SRAM banks that share the read address, write address and write data).
- The writer side accepts a valid/ready stream and fills one bank. The reader side drains the other bank as a valid/ready stream.
- Banks swap when a full frame has been written and the previous frame has been fully drained.
- Sits between a layer's output engine and the next layer's input fetch.

---
 rtl/pingpong_sram_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pingpong_sram_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_sram_ctrl.sv
// Ping-pong activation buffer controller.
// The writer fills one SRAM bank from a valid/ready stream. The reader drains the
// other bank into a valid/ready stream through a 2-entry skid. The banks swap once
// the writer holds a full frame and the reader has gone idle.
//
// writer state | meaning
// W_FILL       | accepting words into wr_bank at address wcnt
// W_FULL       | frame complete, in_ready low, waiting for the swap
//
// reader state | meaning
// R_IDLE       | nothing to drain, read strobes inactive
// R_DRAIN      | issuing reads from rd_bank and streaming them out
module pingpong_sram_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int FRAME_LEN  = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  frame_swap,
  output logic                  cs1_rd,
  output logic                  oe1_rd,
  output logic                  we1_rd,
  output logic                  cs2_rd,
  output logic                  oe2_rd,
  output logic                  we2_rd,
  output logic                  cs1_wr,
  output logic                  oe1_wr,
  output logic                  we1_wr,
  output logic                  cs2_wr,
  output logic                  oe2_wr,
  output logic                  we2_wr,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr,
  input  logic [DATA_WIDTH-1:0] data1_rd,
  input  logic [DATA_WIDTH-1:0] data2_rd
);

  // One extra counter bit so FRAME_LEN = 2^ADDR_WIDTH is representable.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {W_FILL, W_FULL} wr_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic wr_bank_q;
  logic rd_bank;
  logic swap;
  logic wr_fire;
  logic rd_issue;
  logic pop;

  // Read pipeline: one cycle between strobe and data on the bank port.
  logic inflight_q;
  logic inflight_bank_q;
  logic inflight_last_q;
  logic [DATA_WIDTH-1:0] rd_word;

  // Two-entry skid holding returned words until the consumer takes them.
  logic [1:0][DATA_WIDTH-1:0] skid_data_q;
  logic [1:0]                 skid_last_q;
  logic [1:0]                 skid_cnt_q;
  logic                       skid_wp_q;
  logic                       skid_rp_q;
  logic [2:0]                 occ_next;

  assign rd_bank = ~wr_bank_q;
  assign swap    = (wr_state_q == W_FULL) && (rd_state_q == R_IDLE);

  assign out_valid = (skid_cnt_q != 2'd0);
  assign out_data  = skid_data_q[skid_rp_q];
  assign out_last  = skid_last_q[skid_rp_q] & out_valid;
  assign pop       = out_valid & out_ready;
  assign rd_word   = inflight_bank_q ? data2_rd : data1_rd;

  // Words that will still be held or in flight after this cycle's pop; a new
  // read is only issued if it will have a skid slot waiting for it.
  assign occ_next = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Writer next-state: accept words while filling, wait for the swap when full.
  always_comb begin
    wr_state_d = wr_state_q;
    wcnt_d     = wcnt_q;
    in_ready   = 1'b0;
    wr_fire    = 1'b0;
    unique case (wr_state_q)
      W_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_fire = 1'b1;
          wcnt_d  = wcnt_q + 1'b1;
          if (wcnt_q == LAST_IDX) wr_state_d = W_FULL;
        end
      end
      W_FULL: begin
        if (swap) begin
          wr_state_d = W_FILL;
          wcnt_d     = '0;
        end
      end
    endcase
  end

  // Reader next-state: start on swap, issue reads while the skid has room,
  // return to idle once the last word of the frame is accepted.
  always_comb begin
    rd_state_d = rd_state_q;
    rcnt_d     = rcnt_q;
    rd_issue   = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (swap) begin
          rd_state_d = R_DRAIN;
          rcnt_d     = '0;
        end
      end
      R_DRAIN: begin
        if ((rcnt_q < FRAME_CNT) && (occ_next < 3'd2)) begin
          rd_issue = 1'b1;
          rcnt_d   = rcnt_q + 1'b1;
        end
        if (pop && out_last) rd_state_d = R_IDLE;
      end
    endcase
  end

  // SRAM strobes; each port only ever addresses its own bank of the pair.
  assign cs1_wr  = ~(wr_fire & ~wr_bank_q);
  assign we1_wr  = ~(wr_fire & ~wr_bank_q);
  assign oe1_wr  = 1'b1;
  assign cs2_wr  = ~(wr_fire & wr_bank_q);
  assign we2_wr  = ~(wr_fire & wr_bank_q);
  assign oe2_wr  = 1'b1;
  assign cs1_rd  = ~(rd_issue & ~rd_bank);
  assign oe1_rd  = ~(rd_issue & ~rd_bank);
  assign we1_rd  = 1'b1;
  assign cs2_rd  = ~(rd_issue & rd_bank);
  assign oe2_rd  = ~(rd_issue & rd_bank);
  assign we2_rd  = 1'b1;
  assign addr_wr = wcnt_q[ADDR_WIDTH-1:0];
  assign addr_rd = rcnt_q[ADDR_WIDTH-1:0];
  assign data_wr = wr_fire ? in_data : '0;

  // FSM state, counters, bank select and the swap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_FILL;
      rd_state_q <= R_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      wr_bank_q  <= 1'b0;
      frame_swap <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      frame_swap <= swap;
      if (swap) wr_bank_q <= ~wr_bank_q;
    end
  end

  // Remember which bank and frame position each outstanding read belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_bank_q <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rd_issue;
      inflight_bank_q <= rd_bank;
      inflight_last_q <= (rcnt_q == LAST_IDX);
    end
  end

  // Skid FIFO: push returning read data, pop on output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_data_q <= '0;
      skid_last_q <= '0;
      skid_cnt_q  <= 2'd0;
      skid_wp_q   <= 1'b0;
      skid_rp_q   <= 1'b0;
    end else begin
      if (inflight_q) begin
        skid_data_q[skid_wp_q] <= rd_word;
        skid_last_q[skid_wp_q] <= inflight_last_q;
        skid_wp_q              <= ~skid_wp_q;
      end
      if (pop) skid_rp_q <= ~skid_rp_q;
      case ({inflight_q, pop})
        2'b10:   skid_cnt_q <= skid_cnt_q + 2'd1;
        2'b01:   skid_cnt_q <= skid_cnt_q - 2'd1;
        default: skid_cnt_q <= skid_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_sram_ctrl.sv
// Bench for pingpong_sram_ctrl with FRAME_LEN=4 and behavioural models of both banks.
module tb_pingpong_sram_ctrl;

  localparam int DW = 16;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic out_last;
  logic frame_swap;
  logic cs1_rd, oe1_rd, we1_rd, cs2_rd, oe2_rd, we2_rd;
  logic cs1_wr, oe1_wr, we1_wr, cs2_wr, oe2_wr, we2_wr;
  logic [AW-1:0] addr_rd, addr_wr;
  logic [DW-1:0] data_wr;
  logic [DW-1:0] data1_rd = '0;
  logic [DW-1:0] data2_rd = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int excl_viol = 0;
  int ovf_viol  = 0;
  int out_cnt   = 0;

  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];

  pingpong_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_swap(frame_swap),
    .cs1_rd(cs1_rd), .oe1_rd(oe1_rd), .we1_rd(we1_rd),
    .cs2_rd(cs2_rd), .oe2_rd(oe2_rd), .we2_rd(we2_rd),
    .cs1_wr(cs1_wr), .oe1_wr(oe1_wr), .we1_wr(we1_wr),
    .cs2_wr(cs2_wr), .oe2_wr(oe2_wr), .we2_wr(we2_wr),
    .addr_rd(addr_rd), .addr_wr(addr_wr), .data_wr(data_wr),
    .data1_rd(data1_rd), .data2_rd(data2_rd)
  );

  always #5 clk = ~clk;

  // Synchronous bank models: write on strobe, read data valid the next cycle.
  always @(posedge clk) begin
    if (!cs1_wr && !we1_wr) mem1[addr_wr] <= data_wr;
    if (!cs2_wr && !we2_wr) mem2[addr_wr] <= data_wr;
    if (!cs1_rd && !oe1_rd) data1_rd <= mem1[addr_rd];
    if (!cs2_rd && !oe2_rd) data2_rd <= mem2[addr_rd];
  end

  // Bank exclusivity and read-outstanding monitors.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= 0;
    end else begin
      if ((!cs1_wr && !cs1_rd) || (!cs2_wr && !cs2_rd)) excl_viol <= excl_viol + 1;
      out_cnt <= out_cnt + int'(!cs1_rd || !cs2_rd) - int'(out_valid && out_ready);
      if (out_cnt + int'(!cs1_rd || !cs2_rd) - int'(out_valid && out_ready) > 2)
        ovf_viol <= ovf_viol + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic reset_checks();
    check("rst_strobes", {cs1_rd, oe1_rd, we1_rd, cs2_rd, oe2_rd, we2_rd,
                          cs1_wr, oe1_wr, we1_wr, cs2_wr, oe2_wr, we2_wr}, 32'hfff);
    check("rst_addr_rd", addr_rd, 0);
    check("rst_addr_wr", addr_wr, 0);
    check("rst_data_wr", data_wr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_swap", frame_swap, 0);
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_irdy;
    logic          e_cs1w;
    logic          e_cs2w;
    logic [AW-1:0] e_aw;
    logic          e_cs1r;
    logic          e_cs2r;
    logic [AW-1:0] e_ar;
    logic          e_fs;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ol;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [DW-1:0] id, logic ordy, logic irdy,
                              logic c1w, logic c2w, logic [AW-1:0] aw,
                              logic c1r, logic c2r, logic [AW-1:0] ar,
                              logic fs, logic ov, logic [DW-1:0] od, logic ol);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.e_irdy = irdy;
    v.e_cs1w = c1w; v.e_cs2w = c2w; v.e_aw = aw;
    v.e_cs1r = c1r; v.e_cs2r = c2r; v.e_ar = ar;
    v.e_fs = fs; v.e_ov = ov; v.e_od = od; v.e_ol = ol;
    return v;
  endfunction

  task automatic run_table();
    foreach (tbl[r]) begin
      @(negedge clk);
      in_valid  = tbl[r].iv;
      in_data   = tbl[r].id;
      out_ready = tbl[r].ordy;
      #1;
      check($sformatf("row%0d_in_ready", r), in_ready, tbl[r].e_irdy);
      check($sformatf("row%0d_wr1", r), {cs1_wr, we1_wr, oe1_wr}, {tbl[r].e_cs1w, tbl[r].e_cs1w, 1'b1});
      check($sformatf("row%0d_wr2", r), {cs2_wr, we2_wr, oe2_wr}, {tbl[r].e_cs2w, tbl[r].e_cs2w, 1'b1});
      check($sformatf("row%0d_rd1", r), {cs1_rd, oe1_rd, we1_rd}, {tbl[r].e_cs1r, tbl[r].e_cs1r, 1'b1});
      check($sformatf("row%0d_rd2", r), {cs2_rd, oe2_rd, we2_rd}, {tbl[r].e_cs2r, tbl[r].e_cs2r, 1'b1});
      check($sformatf("row%0d_frame_swap", r), frame_swap, tbl[r].e_fs);
      check($sformatf("row%0d_out_valid", r), out_valid, tbl[r].e_ov);
      if (!tbl[r].e_cs1w || !tbl[r].e_cs2w) begin
        check($sformatf("row%0d_addr_wr", r), addr_wr, tbl[r].e_aw);
        check($sformatf("row%0d_data_wr", r), data_wr, tbl[r].id);
      end
      if (!tbl[r].e_cs1r || !tbl[r].e_cs2r)
        check($sformatf("row%0d_addr_rd", r), addr_rd, tbl[r].e_ar);
      if (tbl[r].e_ov) begin
        check($sformatf("row%0d_out_data", r), out_data, tbl[r].e_od);
        check($sformatf("row%0d_out_last", r), out_last, tbl[r].e_ol);
      end
    end
  endtask

  // Accept n words base+1.. with out_ready following pat (bit i on cycle i mod 4).
  task automatic drain(input logic [DW-1:0] base, input logic [3:0] pat, input int n);
    int k = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic held_last = 1'b0;
    while (k < n && cyc < 60) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      #1;
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held);
        check("hold_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        check("drain_data", out_data, base + DW'(k) + 16'd1);
        check("drain_last", out_last, (k == 3));
        k++;
      end
      stalled   = out_valid && !out_ready;
      held      = out_data;
      held_last = out_last;
      cyc++;
    end
    check("drain_count", k, n);
  endtask

  initial begin
    tbl.push_back(mk(1, 'h11, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h12, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h13, 1, 1, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h14, 1, 1, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h21, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h21, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 'h22, 1, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h23, 1, 1, 1, 0, 2, 0, 1, 2, 0, 1, 'h11, 0));
    tbl.push_back(mk(1, 'h24, 1, 1, 1, 0, 3, 0, 1, 3, 0, 1, 'h12, 0));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 1, 0, 1, 1, 0, 0, 1, 'h13, 0));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 1, 0, 1, 1, 0, 0, 1, 'h14, 1));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h31, 1, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 'h32, 1, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h33, 1, 1, 0, 1, 2, 1, 0, 2, 0, 1, 'h21, 0));
    tbl.push_back(mk(1, 'h34, 1, 1, 0, 1, 3, 1, 0, 3, 0, 1, 'h22, 0));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 1, 0, 1, 1, 0, 0, 1, 'h23, 0));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 1, 0, 1, 1, 0, 0, 1, 'h24, 1));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset_checks();
    rst = 1'b0;

    // Frames 1 and 2 through to the swap that starts draining frame 3.
    run_table();

    // Writer fills frame 4 while the reader is stalled, then sits FULL.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 16'h41 + 16'(i);
      out_ready = 1'b0;
      #1;
      check("f4_in_ready", in_ready, 1);
      check("f4_cs2_wr", {cs1_wr, cs2_wr}, 2'b10);
      check("f4_addr_wr", addr_wr, i);
      if (i == 0) begin
        check("f3_swap_pulse", frame_swap, 1);
        check("f3_read_bank1", {cs1_rd, cs2_rd}, 2'b01);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_data = 16'h99;
      #1;
      check("full_in_ready", in_ready, 0);
      check("full_no_write", {cs1_wr, cs2_wr}, 2'b11);
      check("full_no_swap", frame_swap, 0);
      check("stall_head", {out_valid, out_data}, {1'b1, 16'h31});
    end
    in_valid = 1'b0;
    drain(16'h30, 4'b1001, 4);

    // Swap follows the last acceptance: comb one cycle, pulse the next.
    @(negedge clk); out_ready = 1'b1; #1;
    check("sw4_not_yet", frame_swap, 0);
    @(negedge clk); #1;
    check("sw4_pulse", frame_swap, 1);
    check("sw4_read_bank2", {cs1_rd, cs2_rd}, 2'b10);
    @(negedge clk); #1;
    check("sw4_one_cycle", frame_swap, 0);

    // Frame 5's last write lands in the same cycle as frame 4's last acceptance.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h51 + 16'(i);
      #1;
      check("f5_wr_bank1", {cs1_wr, cs2_wr}, 2'b01);
      check("f5_addr_wr", addr_wr, i);
      check("f4_out", {out_valid, out_data, out_last}, {1'b1, 16'h41 + 16'(i), (i == 3)});
    end
    @(negedge clk); in_valid = 1'b0; #1;
    check("sim_no_swap_yet", {frame_swap, in_ready}, 2'b00);
    @(negedge clk); #1;
    check("sim_swap_pulse", frame_swap, 1);
    check("sim_read_bank1", {cs1_rd, cs2_rd}, 2'b01);
    @(negedge clk); #1;
    check("sim_one_pulse", frame_swap, 0);
    drain(16'h50, 4'b1111, 4);

    // Frame 6 into bank 2, then reset after two words of its drain.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h61 + 16'(i);
      #1;
      check("f6_wr_bank2", {cs1_wr, cs2_wr}, 2'b10);
    end
    @(negedge clk); in_valid = 1'b0;
    drain(16'h60, 4'b1111, 2);
    #2 rst = 1'b1;
    #1 reset_checks();
    @(negedge clk);
    rst = 1'b0;

    // After reset the first-frame sequence must repeat exactly.
    run_table();

    check("bank_exclusive", excl_viol, 0);
    check("max_outstanding", ovf_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
